// File: rtl/sm83_sp_sequencer_if.sv
// Purpose : bundle of the request, bus and status signals between the decoder/bus side and the SP sequencer.
// Latency : none (wires only).
// Backpressure: op_valid is held by the requester until op_ready is seen high.
// Ports   : master = decoder/memory side (drives requests, cyc_en, rdata);
//           slave  = sequencer (drives op_ready, bus strobes, SP and status).
interface sm83_sp_sequencer_if;
    logic        cyc_en;
    logic        op_valid;
    logic [2:0]  op;
    logic        op_ready;
    logic [15:0] hl;
    logic [15:0] val;
    logic [7:0]  e8;
    logic [7:0]  rdata;
    logic [15:0] addr;
    logic        addr_oe;
    logic        rd;
    logic        wr;
    logic [7:0]  wdata;
    logic [15:0] pop_val;
    logic        flag_h;
    logic        flag_c;
    logic [15:0] sp;
    logic        done;

    modport master (
        output cyc_en, op_valid, op, hl, val, e8, rdata,
        input  op_ready, addr, addr_oe, rd, wr, wdata, pop_val, flag_h, flag_c, sp, done
    );

    modport slave (
        input  cyc_en, op_valid, op, hl, val, e8, rdata,
        output op_ready, addr, addr_oe, rd, wr, wdata, pop_val, flag_h, flag_c, sp, done
    );
endinterface

// File: rtl/sm83_sp_sequencer.sv
// Purpose : owns the 16-bit stack pointer; steps PUSH/POP/ADD_SP_E/SP loads across M-cycles, driving SP onto the address bus.
// Latency : accept in IDLE on any edge; PUSH 3, POP 2, ADD_SP_E 2, others 1, NOP 0 cyc_en edges; done pulses the cycle after the final commit.
// Backpressure: op_ready is high only in IDLE; a state advances only on edges with cyc_en=1, strobes hold otherwise.
// Ports   : clk, nreset (synchronous, active-low); bus = slave modport of sm83_sp_sequencer_if.
module sm83_sp_sequencer #(
    parameter logic [15:0] SP_RESET = 16'hFFFE
) (
    input  logic                  clk,
    input  logic                  nreset,
    sm83_sp_sequencer_if.slave    bus
);

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_PUSH     = 3'd1;
    localparam logic [2:0] OP_POP      = 3'd2;
    localparam logic [2:0] OP_LD_SP_HL = 3'd3;
    localparam logic [2:0] OP_ADD_SP_E = 3'd4;
    localparam logic [2:0] OP_LD_SP_IM = 3'd5;
    localparam logic [2:0] OP_INC_SP   = 3'd6;
    localparam logic [2:0] OP_DEC_SP   = 3'd7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_P1,
        ST_P2,
        ST_P3,
        ST_Q1,
        ST_Q2,
        ST_A1,
        ST_A2,
        ST_S1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] sp_q, sp_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] val_q, val_d;
    logic [7:0]  e8_q, e8_d;
    logic [15:0] pop_q, pop_d;
    logic        fh_q, fh_d;
    logic        fc_q, fc_d;
    logic        done_q, done_d;

    // Half/full carries come from the unsigned low-byte sum, independent of e8's sign.
    logic [4:0]  nib_sum;
    logic [8:0]  byte_sum;
    logic [15:0] e8_sext;

    assign nib_sum  = {1'b0, sp_q[3:0]} + {1'b0, e8_q[3:0]};
    assign byte_sum = {1'b0, sp_q[7:0]} + {1'b0, e8_q};
    assign e8_sext  = {{8{e8_q[7]}}, e8_q};

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        op_d    = op_q;
        val_d   = val_q;
        e8_d    = e8_q;
        pop_d   = pop_q;
        fh_d    = fh_q;
        fc_d    = fc_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    op_d  = bus.op;
                    val_d = bus.val;
                    e8_d  = bus.e8;
                    case (bus.op)
                        OP_NOP:      done_d  = 1'b1;
                        OP_PUSH:     state_d = ST_P1;
                        OP_POP:      state_d = ST_Q1;
                        OP_ADD_SP_E: state_d = ST_A1;
                        default:     state_d = ST_S1;
                    endcase
                end
            end
            ST_P1: begin
                if (bus.cyc_en) begin
                    sp_d    = sp_q - 16'd1;
                    state_d = ST_P2;
                end
            end
            ST_P2: begin
                if (bus.cyc_en) begin
                    sp_d    = sp_q - 16'd1;
                    state_d = ST_P3;
                end
            end
            ST_P3: begin
                if (bus.cyc_en) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_Q1: begin
                if (bus.cyc_en) begin
                    pop_d   = {pop_q[15:8], bus.rdata};
                    sp_d    = sp_q + 16'd1;
                    state_d = ST_Q2;
                end
            end
            ST_Q2: begin
                if (bus.cyc_en) begin
                    pop_d   = {bus.rdata, pop_q[7:0]};
                    sp_d    = sp_q + 16'd1;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_A1: begin
                if (bus.cyc_en) begin
                    fh_d    = nib_sum[4];
                    fc_d    = byte_sum[8];
                    state_d = ST_A2;
                end
            end
            ST_A2: begin
                if (bus.cyc_en) begin
                    sp_d    = sp_q + e8_sext;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_S1: begin
                if (bus.cyc_en) begin
                    case (op_q)
                        OP_LD_SP_HL: sp_d = bus.hl;
                        OP_LD_SP_IM: sp_d = val_q;
                        OP_INC_SP:   sp_d = sp_q + 16'd1;
                        OP_DEC_SP:   sp_d = sp_q - 16'd1;
                        default:     sp_d = sp_q;
                    endcase
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            sp_q    <= SP_RESET;
            op_q    <= OP_NOP;
            val_q   <= 16'h0000;
            e8_q    <= 8'h00;
            pop_q   <= 16'h0000;
            fh_q    <= 1'b0;
            fc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            op_q    <= op_d;
            val_q   <= val_d;
            e8_q    <= e8_d;
            pop_q   <= pop_d;
            fh_q    <= fh_d;
            fc_q    <= fc_d;
            done_q  <= done_d;
        end
    end

    // Strobes depend on state alone so they stay put across stalled (cyc_en=0) cycles.
    logic is_wr, is_rd;
    assign is_wr = (state_q == ST_P2) || (state_q == ST_P3);
    assign is_rd = (state_q == ST_Q1) || (state_q == ST_Q2);

    assign bus.op_ready = (state_q == ST_IDLE);
    assign bus.addr_oe  = is_wr || is_rd;
    assign bus.rd       = is_rd;
    assign bus.wr       = is_wr;
    assign bus.addr     = (is_wr || is_rd) ? sp_q : 16'h0000;
    assign bus.wdata    = (state_q == ST_P2) ? val_q[15:8] :
                          (state_q == ST_P3) ? val_q[7:0]  : 8'h00;
    assign bus.pop_val  = pop_q;
    assign bus.flag_h   = fh_q;
    assign bus.flag_c   = fc_q;
    assign bus.sp       = sp_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_sm83_sp_sequencer.sv
module tb_sm83_sp_sequencer;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_LDHL  = 3'd3;
    localparam logic [2:0] OP_ADD   = 3'd4;
    localparam logic [2:0] OP_LDIM  = 3'd5;
    localparam logic [2:0] OP_INC   = 3'd6;
    localparam logic [2:0] OP_DEC   = 3'd7;

    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    sm83_sp_sequencer_if ifc ();

    sm83_sp_sequencer #(.SP_RESET(16'hFFFE)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (ifc.slave)
    );

    // Byte-wide memory model answering the sequencer's bus.
    logic [7:0] mem [0:65535];
    int wr_commits = 0;
    assign ifc.rdata = ifc.rd ? mem[ifc.addr] : 8'h00;
    always @(posedge clk) begin
        if (nreset && ifc.wr && ifc.cyc_en) begin
            mem[ifc.addr] <= ifc.wdata;
            wr_commits = wr_commits + 1;
        end
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op with cyc_en tied high; returns in the done cycle.
    task automatic do_op(input logic [2:0] o, input logic [15:0] v, input logic [7:0] e,
                         input logic [15:0] h, output int steps);
        ifc.cyc_en   = 1'b1;
        ifc.op_valid = 1'b1;
        ifc.op       = o;
        ifc.val      = v;
        ifc.e8       = e;
        ifc.hl       = h;
        tick();
        ifc.op_valid = 1'b0;
        steps = 0;
        while (!ifc.done && steps < 20) begin
            tick();
            steps++;
        end
        check("done_seen", {31'd0, ifc.done}, 32'd1);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] sp0;
        logic [15:0] val;
        logic [7:0]  e8;
        logic [15:0] hl;
        logic [15:0] exp_sp;
        int          exp_steps;
        bit          upd_flags;
        bit          exp_h;
        bit          exp_c;
        bit          upd_pop;
        logic [15:0] exp_pop;
    } vec_t;

    vec_t vecs [12];
    bit   m_h = 1'b0, m_c = 1'b0;
    logic [15:0] m_pop = 16'h0000;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   st;
        int   c0;
        bit   pat   [6] = '{1, 0, 0, 1, 0, 1};
        logic e_wr  [6] = '{1, 1, 1, 1, 1, 0};
        logic [7:0]  e_wd [6] = '{8'h12, 8'h12, 8'h12, 8'h34, 8'h34, 8'h00};
        logic [15:0] e_ad [6] = '{16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFC, 16'hFFFC, 16'h0000};
        logic e_dn  [6] = '{0, 0, 0, 0, 0, 1};

        //            op       sp0       val       e8     hl        exp_sp   stp fl  h  c  pop  exp_pop
        vecs[0]  = '{OP_PUSH, 16'hFFFE, 16'h1234, 8'h00, 16'h0000, 16'hFFFC, 3, 0, 0, 0, 0, 16'h0000};
        vecs[1]  = '{OP_POP,  16'hFFFC, 16'h0000, 8'h00, 16'h0000, 16'hFFFE, 2, 0, 0, 0, 1, 16'h1234};
        vecs[2]  = '{OP_ADD,  16'h00FF, 16'h0000, 8'h01, 16'h0000, 16'h0100, 2, 1, 1, 1, 0, 16'h0000};
        vecs[3]  = '{OP_ADD,  16'h0000, 16'h0000, 8'hFF, 16'h0000, 16'hFFFF, 2, 1, 0, 0, 0, 16'h0000};
        vecs[4]  = '{OP_ADD,  16'h1008, 16'h0000, 8'hF8, 16'h0000, 16'h1000, 2, 1, 1, 1, 0, 16'h0000};
        vecs[5]  = '{OP_LDHL, 16'h1234, 16'h0000, 8'h00, 16'hC000, 16'hC000, 1, 0, 0, 0, 0, 16'h0000};
        vecs[6]  = '{OP_LDIM, 16'h0000, 16'hBEEF, 8'h00, 16'h0000, 16'hBEEF, 1, 0, 0, 0, 0, 16'h0000};
        vecs[7]  = '{OP_INC,  16'hFFFF, 16'h0000, 8'h00, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 16'h0000};
        vecs[8]  = '{OP_DEC,  16'h0000, 16'h0000, 8'h00, 16'h0000, 16'hFFFF, 1, 0, 0, 0, 0, 16'h0000};
        vecs[9]  = '{OP_NOP,  16'h4321, 16'h0000, 8'h00, 16'h0000, 16'h4321, 0, 0, 0, 0, 0, 16'h0000};
        vecs[10] = '{OP_PUSH, 16'h0001, 16'hABCD, 8'h00, 16'h0000, 16'hFFFF, 3, 0, 0, 0, 0, 16'h0000};
        vecs[11] = '{OP_POP,  16'hFFFF, 16'h0000, 8'h00, 16'h0000, 16'h0001, 2, 0, 0, 0, 1, 16'hABCD};

        ifc.cyc_en = 1'b0; ifc.op_valid = 1'b0; ifc.op = OP_NOP;
        ifc.val = 16'h0; ifc.e8 = 8'h0; ifc.hl = 16'h0;

        // Reset state
        nreset = 1'b0;
        tick(); tick();
        check("rst_sp",      {16'd0, ifc.sp}, 32'hFFFE);
        check("rst_ready",   {31'd0, ifc.op_ready}, 32'd1);
        check("rst_strobes", {29'd0, ifc.addr_oe, ifc.rd, ifc.wr}, 32'd0);
        check("rst_addr",    {16'd0, ifc.addr}, 32'd0);
        check("rst_wdata",   {24'd0, ifc.wdata}, 32'd0);
        check("rst_done",    {31'd0, ifc.done}, 32'd0);
        check("rst_pop",     {16'd0, ifc.pop_val}, 32'd0);
        check("rst_flags",   {30'd0, ifc.flag_h, ifc.flag_c}, 32'd0);
        nreset = 1'b1;
        tick();

        // PUSH bus trace, cyc_en tied high
        ifc.cyc_en = 1'b1; ifc.op_valid = 1'b1; ifc.op = OP_PUSH; ifc.val = 16'h1234;
        tick();
        ifc.op_valid = 1'b0;
        check("push_p1_bus", {15'd0, ifc.addr_oe, ifc.wr, ifc.addr}, 32'd0);
        tick();
        check("push_p2", {7'd0, ifc.addr_oe, ifc.wr, ifc.wdata, ifc.addr}, {7'd0, 2'b11, 8'h12, 16'hFFFD});
        tick();
        check("push_p3", {7'd0, ifc.addr_oe, ifc.wr, ifc.wdata, ifc.addr}, {7'd0, 2'b11, 8'h34, 16'hFFFC});
        tick();
        check("push_done", {15'd0, ifc.done, ifc.sp}, {15'd0, 1'b1, 16'hFFFC});
        check("push_idle_wr", {31'd0, ifc.wr}, 32'd0);
        tick();
        check("push_done_pulse", {31'd0, ifc.done}, 32'd0);

        // PUSH with stalled cycles: accepted while cyc_en=0
        do_op(OP_LDIM, 16'hFFFE, 8'h00, 16'h0, st);
        c0 = wr_commits;
        ifc.cyc_en = 1'b0; ifc.op_valid = 1'b1; ifc.op = OP_PUSH; ifc.val = 16'h1234;
        tick();
        ifc.op_valid = 1'b0;
        check("stall_p1_bus", {30'd0, ifc.addr_oe, ifc.wr}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            ifc.cyc_en = pat[i];
            tick();
            check($sformatf("stall_%0d_bus", i), {6'd0, ifc.done, ifc.wr, ifc.wdata, ifc.addr},
                  {6'd0, e_dn[i], e_wr[i], e_wd[i], e_ad[i]});
        end
        check("stall_wr_commits", wr_commits - c0, 32'd2);
        check("stall_sp", {16'd0, ifc.sp}, 32'hFFFC);

        // POP trace from memory FFFC=34, FFFD=12
        ifc.cyc_en = 1'b1; ifc.op_valid = 1'b1; ifc.op = OP_POP;
        tick();
        ifc.op_valid = 1'b0;
        check("pop_q1", {14'd0, ifc.addr_oe, ifc.rd, ifc.addr}, {14'd0, 2'b11, 16'hFFFC});
        tick();
        check("pop_q2", {14'd0, ifc.addr_oe, ifc.rd, ifc.addr}, {14'd0, 2'b11, 16'hFFFD});
        tick();
        check("pop_val", {16'd0, ifc.pop_val}, 32'h1234);
        check("pop_sp",  {15'd0, ifc.done, ifc.sp}, {15'd0, 1'b1, 16'hFFFE});

        // Reset asserted during P2 of a PUSH
        do_op(OP_LDIM, 16'h8000, 8'h00, 16'h0, st);
        ifc.op_valid = 1'b1; ifc.op = OP_PUSH; ifc.val = 16'h5678;
        tick();
        ifc.op_valid = 1'b0;
        tick();
        check("rstmid_in_p2", {31'd0, ifc.wr}, 32'd1);
        c0 = wr_commits;
        nreset = 1'b0;
        tick();
        check("rstmid_sp", {16'd0, ifc.sp}, 32'hFFFE);
        check("rstmid_state", {28'd0, ifc.op_ready, ifc.wr, ifc.addr_oe, ifc.done}, {28'd0, 4'b1000});
        check("rstmid_pop", {16'd0, ifc.pop_val}, 32'd0);
        nreset = 1'b1;
        tick();
        check("rstmid_after", {29'd0, ifc.wr, ifc.done, ifc.op_ready}, 32'd1);
        check("rstmid_commits", wr_commits - c0, 32'd0);
        check("rstmid_sp2", {16'd0, ifc.sp}, 32'hFFFE);
        m_pop = 16'h0000; m_h = 1'b0; m_c = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            do_op(OP_LDIM, vecs[i].sp0, 8'h00, 16'h0, st);
            do_op(vecs[i].op, vecs[i].val, vecs[i].e8, vecs[i].hl, st);
            if (vecs[i].upd_flags) begin m_h = vecs[i].exp_h; m_c = vecs[i].exp_c; end
            if (vecs[i].upd_pop) m_pop = vecs[i].exp_pop;
            check($sformatf("v%0d_steps", i), st, vecs[i].exp_steps);
            check($sformatf("v%0d_sp", i), {16'd0, ifc.sp}, {16'd0, vecs[i].exp_sp});
            check($sformatf("v%0d_flags", i), {30'd0, ifc.flag_h, ifc.flag_c}, {30'd0, m_h, m_c});
            check($sformatf("v%0d_pop", i), {16'd0, ifc.pop_val}, {16'd0, m_pop});
            tick();
            check($sformatf("v%0d_done_clear", i), {30'd0, ifc.done, ifc.op_ready}, 32'd1);
        end

        // INC wrap, then DEC accepted in the done cycle
        do_op(OP_LDIM, 16'hFFFF, 8'h00, 16'h0, st);
        do_op(OP_INC, 16'h0, 8'h00, 16'h0, st);
        check("b2b_inc_sp", {16'd0, ifc.sp}, 32'h0000);
        check("b2b_ready_in_done", {30'd0, ifc.op_ready, ifc.done}, 32'd3);
        do_op(OP_DEC, 16'h0, 8'h00, 16'h0, st);
        check("b2b_dec_steps", st, 32'd1);
        check("b2b_dec_sp", {16'd0, ifc.sp}, 32'hFFFF);
        tick();
        check("b2b_done_clear", {31'd0, ifc.done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sm83_sp_sequencer.md
# sm83_sp_sequencer

Sequencer and owner of the 16-bit stack pointer in the SM83 core. It accepts one stack operation at a time from the decoder and steps it across M-cycles, one step per `cyc_en` strobe. On each step it drives the SP value onto the address bus, issues memory read/write strobes, selects the byte to write, and updates SP. It replaces ad-hoc SP output-enable decode with a single registered state machine between the decoder and the address/data buses.

## Interface
Parameters:
- `SP_RESET`, 16'hFFFE, SP value loaded on reset.

Ports:
- `clk` in 1: single core clock; all state changes on its rising edge.
- `nreset` in 1: reset, synchronous, active-low.
- `cyc_en` in 1: M-cycle advance strobe; a step commits only on an edge where this is 1.
- `op_valid` in 1: operation request.
- `op` in 3: operation code. 0 NOP, 1 PUSH, 2 POP, 3 LD_SP_HL, 4 ADD_SP_E, 5 LD_SP_IMM, 6 INC_SP, 7 DEC_SP.
- `op_ready` out 1: high only in IDLE.
- `hl` in 16: source for LD_SP_HL.
- `val` in 16: word to push (PUSH) or load (LD_SP_IMM); sampled at acceptance.
- `e8` in 8: signed offset for ADD_SP_E; sampled at acceptance.
- `rdata` in 8: memory read data, valid on the committing edge of a read step.
- `addr` out 16: equals SP while `addr_oe` is 1, otherwise 0.
- `addr_oe`, `rd`, `wr` out 1 each: bus strobes for the current step.
- `wdata` out 8: write byte; 0 when `wr` is 0.
- `pop_val` out 16: word assembled by POP.
- `flag_h`, `flag_c` out 1 each: ADD_SP_E flags.
- `sp` out 16: current SP register.
- `done` out 1: one-clk pulse after the final step commits.

## Operation
- States: IDLE, P1, P2, P3 (PUSH), Q1, Q2 (POP), A1, A2 (ADD_SP_E), S1 (single-step ops).
- IDLE: `op_ready`=1. On an edge with `op_valid`=1, the block latches `op`, `val`, and `e8`, then goes to the op's first state. NOP goes straight back to IDLE and pulses `done` next cycle. Acceptance does not require `cyc_en`.
- PUSH:
  - P1 internal, no bus: SP←SP−1.
  - P2: `addr_oe`,`wr`; `wdata`=val[15:8]; SP←SP−1.
  - P3: `addr_oe`,`wr`; `wdata`=val[7:0]; SP unchanged. Final.
- POP:
  - Q1: `addr_oe`,`rd`; pop_val[7:0]←rdata; SP←SP+1.
  - Q2: `addr_oe`,`rd`; pop_val[15:8]←rdata; SP←SP+1. Final.
- ADD_SP_E:
  - A1 internal: low sum = SP[7:0]+e8 (unsigned, 9 bits). flag_h←carry out of bit 3; flag_c←carry out of bit 7.
  - A2 internal: SP←SP+sign_extend(e8). Final.
  - Flags are otherwise held; no other op modifies them.
- S1, internal, final:
  - LD_SP_HL: SP←hl (sampled at the commit edge).
  - LD_SP_IMM: SP←latched val.
  - INC_SP: SP←SP+1.
  - DEC_SP: SP←SP−1.
- Bus strobes are decoded combinationally from state only. They hold their value while `cyc_en`=0, and the state does not advance.
- All SP arithmetic is modulo 2^16: FFFF+1=0000, 0000−1=FFFF.
- The final commit returns the block to IDLE and sets `done` for the next clk. `op_ready` is high in that same cycle, so a back-to-back accept is allowed.

## Timing
- Reset (`nreset`=0 at an edge):
  - sp=SP_RESET; state IDLE; `op_ready`=1.
  - `addr_oe`=`rd`=`wr`=0; `addr`=0; `wdata`=0.
  - `done`=0; pop_val=0; flag_h=flag_c=0.
  - Reset mid-operation abandons the op with no partial SP result beyond SP_RESET.
- Step counts (`cyc_en` edges after acceptance): PUSH 3, POP 2, ADD_SP_E 2, others 1, NOP 0.
- With `cyc_en` tied to 1: accept at edge N, final commit at edge N+k, `done` high during cycle N+k→N+k+1.
- `op_valid` while not IDLE is ignored; the requester holds it until it sees `op_ready`.
- `rdata` is sampled only on committing edges of Q1/Q2.

## Test plan
- Reset → sp=FFFE, `op_ready`=1, all strobes 0, `done`=0. Reset asserted during P2 of a PUSH → sp=FFFE and IDLE next cycle, no further `wr`.
- SP=FFFE, PUSH val=1234, `cyc_en`=1 → P1 no bus. P2: addr=FFFD, wr, wdata=12. P3: addr=FFFC, wr, wdata=34. Then sp=FFFC and one `done` pulse.
- SP=FFFC, POP, memory FFFC=34, FFFD=12 → rd at FFFC then FFFD. Then pop_val=1234, sp=FFFE.
- `cyc_en` toggling 1,0,0,1,0,1 during PUSH → state and strobes frozen on 0 cycles. Exactly 3 commits, identical bus trace.
- ADD_SP_E:
  - SP=00FF, e8=01 → sp=0100, flag_h=1, flag_c=1.
  - SP=0000, e8=FF → sp=FFFF, flag_h=0, flag_c=0.
- Wrap and back-to-back:
  - SP=FFFF INC_SP → 0000; then DEC_SP accepted in the `done` cycle → FFFF.
  - LD_SP_HL hl=C000 → sp=C000.
  - NOP → `done` one cycle after acceptance, SP unchanged.
